// File: rtl/core_io_pkg.sv
// Shared types and constants for the core's serial output path.
// Holds the transmitter state encoding and the framing geometry.
package core_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_BITS  = 8;
  localparam int WORD_BYTES = 2;
  localparam int WORD_W     = UART_BITS * WORD_BYTES;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_next;
  logic [PW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_next = wr_ptr + PW'(do_push);
    rd_next = rd_ptr + PW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (wr_next[PW-1] != rd_next[PW-1]) &&
                (wr_next[AW-1:0] == rd_next[AW-1:0]);
      empty  <= (wr_next == rd_next);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/core_uart_tx.sv
// Serial output port: queues 16-bit core output words and sends each as
// two 8N1 bytes (high byte first) on Tx, running on the undivided clock.
module core_uart_tx
  import core_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 4
) (
  input  logic        Clock,
  input  logic        n_reset,
  input  logic        WriteOut,
  input  logic [15:0] DataOut,
  input  logic        ClearOvf,
  output logic        Full,
  output logic        Busy,
  output logic        Overflow,
  output logic        Tx,
  output logic [1:0]  dbg_state
);

  // Handshake: WriteOut is a one-cycle strobe with DataOut valid alongside it;
  // the word is taken on that edge only if Full was low before the edge,
  // otherwise it is lost and Overflow latches until ClearOvf.

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(UART_BITS);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_BITS - 1);

  tx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic                 byte_lo;
  logic [UART_BITS-1:0] shreg;
  logic [UART_BITS-1:0] lo_byte;
  logic [WORD_W-1:0]    head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 bit_end;
  logic                 pop;
  logic                 ovf;

  assign bit_end = (timer == BIT_LAST);

  // Pop either from idle or straight out of the low byte's stop bit.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == STOP) && bit_end && byte_lo));

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (Clock),
    .n_reset (n_reset),
    .push    (WriteOut),
    .pop     (pop),
    .wdata   (DataOut),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge Clock) begin
    if (!n_reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      byte_lo <= 1'b0;
      shreg   <= '0;
      lo_byte <= '0;
      Tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          Tx    <= 1'b1;
          if (pop) begin
            shreg   <= head[WORD_W-1:UART_BITS];
            lo_byte <= head[UART_BITS-1:0];
            byte_lo <= 1'b0;
            Tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            Tx      <= shreg[0];
            state   <= DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              Tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shreg   <= shreg >> 1;
              Tx      <= shreg[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (!byte_lo) begin
              shreg   <= lo_byte;
              byte_lo <= 1'b1;
              Tx      <= 1'b0;
              state   <= START;
            end else if (pop) begin
              shreg   <= head[WORD_W-1:UART_BITS];
              lo_byte <= head[UART_BITS-1:0];
              byte_lo <= 1'b0;
              Tx      <= 1'b0;
              state   <= START;
            end else begin
              byte_lo <= 1'b0;
              Tx      <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          timer <= '0;
          Tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Set beats clear when a dropped push and ClearOvf land on the same edge.
  always_ff @(posedge Clock) begin
    if (!n_reset) begin
      ovf <= 1'b0;
    end else if (WriteOut && fifo_full) begin
      ovf <= 1'b1;
    end else if (ClearOvf) begin
      ovf <= 1'b0;
    end
  end

  assign Full      = fifo_full;
  assign Overflow  = ovf;
  assign Busy      = (state != IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_core_uart_tx.sv
// Bench for core_uart_tx: word-timeline reference model, per-cycle output
// checks, and a UART line decoder feeding a scoreboard of expected words.
module tb_core_uart_tx;

  localparam int N        = 4;
  localparam int D        = 4;
  localparam int WORD_CYC = 20 * N;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        WriteOut = 1'b0;
  logic [15:0] DataOut = '0;
  logic        ClearOvf = 1'b0;
  logic        Full;
  logic        Busy;
  logic        Overflow;
  logic        Tx;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // Scoreboard of words expected on the line, in order.
  logic [15:0] exp_q[$];

  // Reference model: words waiting, current word and cycles left on the line.
  logic [15:0] m_q[$];
  logic [15:0] m_cur = '0;
  int          m_rem = 0;
  logic        m_ovf = 1'b0;
  bit          chk_en = 1'b0;

  // Line decoder state.
  bit          rx_act = 1'b0;
  int          rx_cyc = 0;
  logic        rx_val = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  rx_hi = '0;
  bit          rx_have = 1'b0;

  always #5 clk = ~clk;

  core_uart_tx #(
    .CLKS_PER_BIT (N),
    .DEPTH        (D)
  ) dut (
    .Clock     (clk),
    .n_reset   (n_reset),
    .WriteOut  (WriteOut),
    .DataOut   (DataOut),
    .ClearOvf  (ClearOvf),
    .Full      (Full),
    .Busy      (Busy),
    .Overflow  (Overflow),
    .Tx        (Tx),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected line level from the position inside the current 20-bit word.
  function automatic logic exp_tx();
    int e, bp, b;
    logic [7:0] bv;
    if (m_rem == 0) return 1'b1;
    e  = WORD_CYC - m_rem;
    bp = e / N;
    bv = (bp < 10) ? m_cur[15:8] : m_cur[7:0];
    b  = bp % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return bv[b-1];
  endfunction

  // ---------------- reference model (updates on each active edge) ----------
  initial begin
    forever begin
      @(posedge clk);
      if (!n_reset) begin
        m_q.delete();
        exp_q.delete();
        m_rem  = 0;
        m_ovf  = 1'b0;
        chk_en = 1'b1;
      end else begin
        bit was_full;
        was_full = (m_q.size() == D);
        if (m_rem > 0) m_rem--;
        if (m_rem == 0 && m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_rem = WORD_CYC;
        end
        if (WriteOut && !was_full) begin
          m_q.push_back(DataOut);
          exp_q.push_back(DataOut);
        end
        if (WriteOut && was_full) m_ovf = 1'b1;
        else if (ClearOvf)        m_ovf = 1'b0;
      end
    end
  end

  // ---------------- monitor: per-cycle outputs and line decoder ------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("tx", Tx, exp_tx());
        check("full", Full, (m_q.size() == D));
        check("busy", Busy, (m_rem > 0) || (m_q.size() > 0));
        check("overflow", Overflow, m_ovf);
        check("state_idle", (dbg_state == 2'd0), (m_rem == 0));
        if (!n_reset) begin
          rx_act  = 1'b0;
          rx_have = 1'b0;
        end else begin
          if (!rx_act) begin
            if (Tx == 1'b0) begin
              rx_act = 1'b1;
              rx_cyc = 0;
            end
          end else begin
            rx_cyc++;
          end
          if (rx_act) begin
            int k, off;
            k   = rx_cyc / N;
            off = rx_cyc % N;
            if (off == 0) begin
              rx_val = Tx;
              if (k >= 1 && k <= 8) rx_byte[k-1] = Tx;
            end else begin
              check("bit_hold", Tx, rx_val);
            end
            if (rx_cyc == 10 * N - 1) begin
              check("stop_bit", rx_val, 1);
              rx_act = 1'b0;
              if (!rx_have) begin
                rx_hi   = rx_byte;
                rx_have = 1'b1;
              end else begin
                rx_have = 1'b0;
                if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_word: got %0h expected none at %0t", {rx_hi, rx_byte}, $time);
                end else begin
                  check("word", {rx_hi, rx_byte}, exp_q.pop_front());
                end
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called aligned to a negedge) -------------
  task automatic drive(input logic we, input logic [15:0] d, input logic clr);
    WriteOut = we;
    DataOut  = d;
    ClearOvf = clr;
    @(negedge clk);
    WriteOut = 1'b0;
    ClearOvf = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int i;
    i = 0;
    while ((m_rem > 0 || m_q.size() > 0) && i < limit) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (m_rem > 0 || m_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", i);
    end
    idle(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(3);
    n_reset = 1'b1;
    idle(2);
    check("reset_tx", Tx, 1);
    check("reset_busy", Busy, 0);

    // Single word
    drive(1'b1, 16'hA55A, 1'b0);
    wait_drain(200);

    // Back-to-back on consecutive cycles
    drive(1'b1, 16'h0001, 1'b0);
    drive(1'b1, 16'hFF00, 1'b0);
    wait_drain(300);

    // Overflow: one word in flight, then five pushes
    drive(1'b1, 16'h1111, 1'b0);
    idle(3);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h2000 + i), 1'b0);
    check("ovf_set", Overflow, 1);
    check("ovf_full", Full, 1);
    drive(1'b0, 16'h0, 1'b1);
    check("ovf_cleared", Overflow, 0);
    // Clear coinciding with a dropped push
    drive(1'b1, 16'hDEAD, 1'b1);
    check("ovf_set_wins", Overflow, 1);
    drive(1'b0, 16'h0, 1'b1);
    check("ovf_cleared2", Overflow, 0);
    wait_drain(600);

    // Reset during data bit 3 of the first byte
    drive(1'b1, 16'hC35A, 1'b0);
    idle(4 * N + 2);
    n_reset = 1'b0;
    idle(1);
    check("midrst_tx", Tx, 1);
    check("midrst_busy", Busy, 0);
    check("midrst_full", Full, 0);
    n_reset = 1'b1;
    idle(2);
    drive(1'b1, 16'h1234, 1'b0);
    wait_drain(200);

    // Push on the same edge the stop bit pops, with three words queued
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h5A00 + i), 1'b0);
    begin
      int i;
      i = 0;
      while (!(m_rem == 1 && m_q.size() == 3) && i < 200) begin
        idle(1);
        i++;
      end
      checks++;
      if (i >= 200) begin
        failures++;
        $display("FAIL pushpop_wait: got no pop point expected one within 200 cycles");
      end
    end
    drive(1'b1, 16'hBEEF, 1'b0);
    check("pushpop_full", Full, 0);
    check("pushpop_busy", Busy, 1);
    wait_drain(600);

    // Randomised traffic
    for (int i = 0; i < 120; i++) begin
      idle($urandom_range(0, 50));
      drive($urandom_range(0, 7) != 0, 16'($urandom), $urandom_range(0, 12) == 0);
    end
    wait_drain(600);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
